save_path_sequencer: RTL

SAVE_PATH_SEQUENCER -- requirements
Module: save_path_sequencer

---
 rtl/save_path_sequencer_pkg.sv | 23 ++
 rtl/save_path_sequencer_save_index_counter.sv | 19 +
 rtl/save_path_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/save_path_sequencer_pkg.sv
// Shared types and constants for the save-path sequencer.
// SAVE_PATH_RETRY_EN (optional) enables one automatic dataslot retry after a host error.
package save_path_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PACK,
    TERM,
    REQ,
    WAIT,
    FINISH
  } state_t;

  localparam int unsigned PATH_LEN   = 32;
  localparam int unsigned WORD_COUNT = 9;

  // Shifts one path byte into the low end so the first byte ends up in [31:24].
  function automatic logic [31:0] pack_byte(input logic [31:0] word, input logic [7:0] b);
    return (word << 8) | {24'd0, b};
  endfunction

endpackage

// File: rtl/save_path_sequencer_save_index_counter.sv
// Save index wrap counter: resets to MAX_INDEX so the first step yields 0.
module save_index_counter #(
  parameter int unsigned MAX_INDEX = 99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  output logic [6:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 7'(MAX_INDEX);
    end else if (step) begin
      count <= (count == 7'(MAX_INDEX)) ? '0 : count + 7'd1;
    end
  end

endmodule

// File: rtl/save_path_sequencer.sv
// Copies a 32-byte save path from the path ROM into the bridge buffer, then runs the dataslot handshake.
// Optional macro SAVE_PATH_RETRY_EN: retry the dataslot request once after a host error.
module save_path_sequencer
  import save_path_sequencer_pkg::*;
#(
  parameter logic [7:0]  BUF_BASE  = 8'h00,
  parameter int unsigned MAX_INDEX = 99
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        save_req,
  output logic [6:0]  save_index,
  output logic [7:0]  path_addr,
  input  logic [7:0]  path_q,
  output logic        buf_wr,
  output logic [7:0]  buf_addr,
  output logic [31:0] buf_data,
  output logic        slot_req,
  input  logic        slot_ack,
  input  logic        slot_done,
  input  logic        slot_err,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t      state, state_nx;
  logic [4:0]  rd_idx;
  logic [31:0] word_q;
  logic        err_q;
  logic        start;
`ifdef SAVE_PATH_RETRY_EN
  logic        retried;
`endif

  assign start = (state == IDLE) && save_req;

  save_index_counter #(.MAX_INDEX(MAX_INDEX)) u_index (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (start),
    .count   (save_index)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    slot_req = (state == REQ);
    done     = (state == FINISH) && !err_q;
    error    = (state == FINISH) && err_q;
    case (state)
      IDLE:   if (save_req) state_nx = FETCH;
      FETCH:  state_nx = PACK;
      PACK:   if (rd_idx == 5'(PATH_LEN - 1)) state_nx = TERM;
      TERM:   state_nx = REQ;
      REQ:    if (slot_ack) state_nx = WAIT;
      WAIT: begin
        if (slot_done) begin
`ifdef SAVE_PATH_RETRY_EN
          state_nx = (slot_err && !retried) ? REQ : FINISH;
`else
          state_nx = FINISH;
`endif
        end
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // path_q in PACK belongs to the address issued one cycle earlier, so rd_idx trails path_addr by one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      path_addr <= '0;
      rd_idx    <= '0;
      word_q    <= '0;
      buf_wr    <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      err_q     <= 1'b0;
`ifdef SAVE_PATH_RETRY_EN
      retried   <= 1'b0;
`endif
    end else begin
      buf_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (save_req) begin
            path_addr <= '0;
            rd_idx    <= '0;
            err_q     <= 1'b0;
`ifdef SAVE_PATH_RETRY_EN
            retried   <= 1'b0;
`endif
          end
        end
        FETCH: path_addr <= 8'd1;
        PACK: begin
          if (rd_idx < 5'(PATH_LEN - 2)) path_addr <= path_addr + 8'd1;
          word_q <= pack_byte(word_q, path_q);
          rd_idx <= rd_idx + 5'd1;
          if (rd_idx[1:0] == 2'b11) begin
            buf_wr   <= 1'b1;
            buf_addr <= BUF_BASE + {5'd0, rd_idx[4:2]};
            buf_data <= pack_byte(word_q, path_q);
          end
        end
        TERM: begin
          buf_wr   <= 1'b1;
          buf_addr <= BUF_BASE + 8'(WORD_COUNT - 1);
          buf_data <= '0;
        end
        WAIT: begin
          if (slot_done) begin
            err_q   <= slot_err;
`ifdef SAVE_PATH_RETRY_EN
            retried <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
